// File: rtl/wb_gain_estimator_pkg.sv
// Shared constants, colour codes, FSM states and the gain clamp for the
// gray-world white-balance gain estimator.
package wb_gain_estimator_pkg;

  localparam int unsigned COLOR_DEPTH   = 8;
  localparam int unsigned GAIN_BIT_CNT  = 12;
  localparam int unsigned GAIN_FRAC     = 8;
  localparam int unsigned COLOR_BIT_CNT = 2;
  localparam int unsigned DIV_W         = COLOR_DEPTH + GAIN_FRAC;

  localparam logic [GAIN_BIT_CNT-1:0] GAIN_ONE = GAIN_BIT_CNT'(1 << GAIN_FRAC);
  localparam logic [GAIN_BIT_CNT-1:0] GAIN_MAX = '1;

  typedef enum logic [COLOR_BIT_CNT-1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    VOID  = 2'd3
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_MEAN  = 3'd2,
    ST_DIV_R = 3'd3,
    ST_DIV_B = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Quotients beyond the gain range, and any divide by zero, pin to full scale.
  function automatic logic [GAIN_BIT_CNT-1:0] clamp_gain(input logic [DIV_W-1:0] q,
                                                         input logic             dbz);
    if (dbz || (q > DIV_W'(GAIN_MAX))) return GAIN_MAX;
    return q[GAIN_BIT_CNT-1:0];
  endfunction

endpackage

// File: rtl/wb_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, the first bit resolved
// on the start edge, so DVD_W edges from start to the final bit.
module wb_serial_divider #(
  parameter int unsigned DVD_W = 16,
  parameter int unsigned DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic [DVD_W-1:0] o_quotient,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DVD_W);

  logic [DVS_W-1:0] r_rem;
  logic [DVD_W-1:0] r_dvd;
  logic [DVS_W-1:0] r_dvs;
  logic [DVD_W-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_dbz;

  logic [DVS_W-1:0] w_rem_src;
  logic [DVS_W-1:0] w_dvs;
  logic [DVS_W:0]   w_trial;
  logic [DVS_W-1:0] w_rem_nxt;
  logic             w_qbit;

  // One restoring step; on start it works straight from the new operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_rem_src = r_rem;
    w_dvs     = r_dvs;
    w_trial   = {r_rem, r_dvd[DVD_W-1]};
    if (i_start) begin
      w_rem_src = '0;
      w_dvs     = i_divisor;
      w_trial   = {w_rem_src, i_dividend[DVD_W-1]};
    end else begin
      w_trial   = {w_rem_src, r_dvd[DVD_W-1]};
    end
    w_qbit    = (w_trial >= {1'b0, w_dvs});
    w_rem_nxt = w_qbit ? DVS_W'(w_trial - {1'b0, w_dvs}) : w_trial[DVS_W-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    if (rst) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_nxt;
      r_dvd  <= i_dividend << 1;
      r_dvs  <= i_divisor;
      r_q    <= {{(DVD_W-1){1'b0}}, w_qbit};
      r_cnt  <= CNT_W'(DVD_W - 1);
      r_done <= 1'b0;
      r_dbz  <= (i_divisor == '0);
    end else if (r_cnt != '0) begin
      r_rem  <= w_rem_nxt;
      r_dvd  <= r_dvd << 1;
      r_q    <= {r_q[DVD_W-2:0], w_qbit};
      r_cnt  <= r_cnt - 1'b1;
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_quotient    = r_q;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;

endmodule

// File: rtl/wb_gain_estimator.sv
// Gray-world white-balance statistics: per-frame colour sums, means and R/B
// gains normalised to green. WB_MANUAL_GAIN_EN adds a manual R/B gain override.
module wb_gain_estimator
  import wb_gain_estimator_pkg::*;
#(
  parameter int unsigned PIX_CNT_LOG2 = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COLOR_DEPTH-1:0]   pixel_in,
  input  logic                     valid_in,
  input  logic [COLOR_BIT_CNT-1:0] color_in,
  input  logic                     last_pic_in,
`ifdef WB_MANUAL_GAIN_EN
  input  logic                     manual_en,
  input  logic [GAIN_BIT_CNT-1:0]  manual_gain_r,
  input  logic [GAIN_BIT_CNT-1:0]  manual_gain_b,
`endif
  output logic                     in_ready,
  output logic [COLOR_DEPTH-1:0]   mean_r,
  output logic [COLOR_DEPTH-1:0]   mean_g,
  output logic [COLOR_DEPTH-1:0]   mean_b,
  output logic [GAIN_BIT_CNT-1:0]  gain_r,
  output logic [GAIN_BIT_CNT-1:0]  gain_g,
  output logic [GAIN_BIT_CNT-1:0]  gain_b,
  output logic                     gain_valid,
  output logic                     busy,
  output logic                     drop_err
);

  localparam int unsigned SUM_W = COLOR_DEPTH + PIX_CNT_LOG2 + 1;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]       s,
                                               input logic [COLOR_DEPTH-1:0] p);
    logic [SUM_W:0] t;
    t = {1'b0, s} + {{(SUM_W+1-COLOR_DEPTH){1'b0}}, p};
    return t[SUM_W] ? '1 : t[SUM_W-1:0];
  endfunction

  function automatic logic [COLOR_DEPTH-1:0] mean_of(input logic [COLOR_DEPTH:0] s_hi);
    return s_hi[COLOR_DEPTH] ? '1 : s_hi[COLOR_DEPTH-1:0];
  endfunction

  state_e r_state, w_state_nxt;

  logic [SUM_W-1:0]        r_sum_r, r_sum_g, r_sum_b;
  logic [COLOR_DEPTH-1:0]  w_mean_r, w_mean_g, w_mean_b;
  logic [COLOR_DEPTH-1:0]  r_lat_mean_r, r_lat_mean_g, r_lat_mean_b;
  logic [GAIN_BIT_CNT-1:0] r_gain_r_calc, r_gain_b_calc;
  logic [COLOR_DEPTH-1:0]  r_mean_r, r_mean_g, r_mean_b;
  logic [GAIN_BIT_CNT-1:0] r_gain_r, r_gain_b;
  logic                    r_gain_valid, r_drop_err;

  logic                    w_accept;
  logic                    w_div_start;
  logic [DIV_W-1:0]        w_div_dividend;
  logic [COLOR_DEPTH-1:0]  w_div_divisor;
  logic [DIV_W-1:0]        w_div_q;
  logic                    w_div_done, w_div_dbz;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign busy     = !in_ready;
  assign w_accept = valid_in && in_ready;

  assign w_mean_r = mean_of(r_sum_r[SUM_W-1:PIX_CNT_LOG2]);
  assign w_mean_g = mean_of(r_sum_g[SUM_W-1:PIX_CNT_LOG2]);
  assign w_mean_b = mean_of(r_sum_b[SUM_W-1:PIX_CNT_LOG2]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The R divide launches from MEAN on the live means; B launches the cycle R finishes.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_start    = 1'b0;
    w_div_dividend = {w_mean_g, {GAIN_FRAC{1'b0}}};
    w_div_divisor  = w_mean_r;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = last_pic_in ? ST_MEAN : ST_ACCUM;
      ST_ACCUM: if (w_accept && last_pic_in) w_state_nxt = ST_MEAN;
      ST_MEAN: begin
        w_div_start = 1'b1;
        w_state_nxt = ST_DIV_R;
      end
      ST_DIV_R: if (w_div_done) begin
        w_div_start    = 1'b1;
        w_div_dividend = {r_lat_mean_g, {GAIN_FRAC{1'b0}}};
        w_div_divisor  = r_lat_mean_b;
        w_state_nxt    = ST_DIV_B;
      end
      ST_DIV_B: if (w_div_done) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  wb_serial_divider #(
    .DVD_W(DIV_W),
    .DVS_W(COLOR_DEPTH)
  ) u_div (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_div_start),
    .i_dividend   (w_div_dividend),
    .i_divisor    (w_div_divisor),
    .o_quotient   (w_div_q),
    .o_done       (w_div_done),
    .o_div_by_zero(w_div_dbz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_r      <= '0;
      r_sum_g      <= '0;
      r_sum_b      <= '0;
      r_lat_mean_r <= '0;
      r_lat_mean_g <= '0;
      r_lat_mean_b <= '0;
    end else if (r_state == ST_MEAN) begin
      r_lat_mean_r <= w_mean_r;
      r_lat_mean_g <= w_mean_g;
      r_lat_mean_b <= w_mean_b;
      r_sum_r      <= '0;
      r_sum_g      <= '0;
      r_sum_b      <= '0;
    end else if (w_accept) begin
      case (color_e'(color_in))
        RED:     r_sum_r <= sat_add(r_sum_r, pixel_in);
        GREEN:   r_sum_g <= sat_add(r_sum_g, pixel_in);
        BLUE:    r_sum_b <= sat_add(r_sum_b, pixel_in);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain_r_calc <= GAIN_ONE;
      r_gain_b_calc <= GAIN_ONE;
      r_mean_r      <= '0;
      r_mean_g      <= '0;
      r_mean_b      <= '0;
      r_gain_r      <= GAIN_ONE;
      r_gain_b      <= GAIN_ONE;
      r_gain_valid  <= 1'b0;
      r_drop_err    <= 1'b0;
    end else begin
      if ((r_state == ST_DIV_R) && w_div_done) r_gain_r_calc <= clamp_gain(w_div_q, w_div_dbz);
      if ((r_state == ST_DIV_B) && w_div_done) r_gain_b_calc <= clamp_gain(w_div_q, w_div_dbz);
      r_gain_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_mean_r <= r_lat_mean_r;
        r_mean_g <= r_lat_mean_g;
        r_mean_b <= r_lat_mean_b;
`ifdef WB_MANUAL_GAIN_EN
        r_gain_r <= manual_en ? manual_gain_r : r_gain_r_calc;
        r_gain_b <= manual_en ? manual_gain_b : r_gain_b_calc;
`else
        r_gain_r <= r_gain_r_calc;
        r_gain_b <= r_gain_b_calc;
`endif
      end
      if (valid_in && !in_ready) r_drop_err <= 1'b1;
    end
  end

  assign mean_r     = r_mean_r;
  assign mean_g     = r_mean_g;
  assign mean_b     = r_mean_b;
  assign gain_r     = r_gain_r;
  assign gain_g     = GAIN_ONE;
  assign gain_b     = r_gain_b;
  assign gain_valid = r_gain_valid;
  assign drop_err   = r_drop_err;

endmodule

// File: doc/wb_gain_estimator.md
Name: wb_gain_estimator

Overview:
- Gray-world white-balance statistics stage, sitting directly upstream of the white-balance/gamma stage.
- Snoops the denoised RGB stream produced by the demosaic/denoise stage and accumulates per-colour sums over one frame.
- At frame end it computes the per-colour means and the R/B gains that normalise them to green.
- The gains are registered and handed to the white-balance multiplier.

Parameters:
- COLOR_DEPTH, 8, bits per colour sample.
- PIX_CNT_LOG2, 20, log2 of pixels per frame (1024x1024); mean = sum >> PIX_CNT_LOG2.
- GAIN_BIT_CNT, 12, unsigned gain width.
- GAIN_FRAC, 8, fractional bits of gain; 1.0 = 256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_in  in  COLOR_DEPTH  colour sample.
- valid_in  in  1  sample qualifier.
- color_in  in  2  RED/GREEN/BLUE/VOID code.
- last_pic_in  in  1  final sample of frame, qualified by valid_in.
- in_ready  out  1  high when samples are accepted (IDLE/ACCUM).
- mean_r, mean_g, mean_b  out  COLOR_DEPTH each  frame means.
- gain_r, gain_g, gain_b  out  GAIN_BIT_CNT each  unsigned Q(GAIN_BIT_CNT-GAIN_FRAC).GAIN_FRAC gains.
- gain_valid  out  1  one-cycle pulse when the gains and means update.
- busy  out  1  high in MEAN/DIV_R/DIV_B/DONE.
- drop_err  out  1  sticky; a valid sample arrived while in_ready=0.

Behaviour:
- Reset values: sums 0, mean_* 0, gain_* 256, gain_valid 0, busy 0, in_ready 1, drop_err 0, state IDLE.
- Reset asserted in any state aborts the current operation; no gain_valid is issued for the aborted frame.
- Accept condition: valid_in & in_ready.
- VOID samples are accepted but not accumulated; last_pic_in on a VOID sample still ends the frame.
- Per-colour sums are COLOR_DEPTH+PIX_CNT_LOG2+1 bits wide and saturate at all-ones (frame overrun guard).
- FSM:
  - IDLE -> ACCUM on the first accepted sample.
  - ACCUM -> MEAN on an accepted sample with last_pic_in=1; that sample is included in the sums.
  - MEAN (1 cycle): mean_c = min(sum_c >> PIX_CNT_LOG2, 2^COLOR_DEPTH-1), latched internally; sums are cleared.
  - DIV_R (COLOR_DEPTH+GAIN_FRAC cycles = 16): restoring divide q = (mean_g << GAIN_FRAC) / mean_r, floor.
  - DIV_B (16 cycles): same computation with mean_b.
  - DONE (1 cycle): registers the outputs, then -> IDLE.
- Output update: mean_*/gain_* update and gain_valid pulses on the edge leaving DONE. gain_g is always 256.
- Gain rules:
  - q > 2^GAIN_BIT_CNT-1 clamps to 4095.
  - Divisor 0 gives 4095; the same 16 cycles are still spent, so latency is constant.
- Latency: with the final-sample edge counted as edge 0, gain_valid is high in the cycle after edge 34 (default parameters).
- Outputs hold between frames.
- in_ready=0 from MEAN through DONE. A valid sample arriving while in_ready=0 is dropped and sets drop_err, which clears only on rst.
- A valid sample in the same cycle as the DONE->IDLE transition is dropped (in_ready is still 0).

Optional Feature:
- Macro WB_MANUAL_GAIN_EN.
- Defined: adds inputs manual_en (1), manual_gain_r (GAIN_BIT_CNT) and manual_gain_b (GAIN_BIT_CNT). If manual_en=1 in DONE, gain_r/gain_b take the manual values, which are sampled in DONE. Means and timing are unchanged.
- Undefined: these ports do not exist and the computed gains are always published.

Decomposition:
- Shared define/package holds:
  - COLOR_DEPTH, GAIN_BIT_CNT, GAIN_FRAC.
  - GAIN_ONE (256) and GAIN_MAX (4095).
  - Colour codes RED/GREEN/BLUE/VOID and COLOR_BIT_CNT.
  - FSM state encodings.
- One sub-module, wb_serial_divider:
  - start/done handshake, one quotient bit per cycle, divide-by-zero flag.
  - Instantiated once and reused for R then B.

Test Plan (PIX_CNT_LOG2=2, i.e. 4 pixels, unless noted):
- Uniform frame R=64, G=128, B=32, each pixel sent R,G,B -> means 64/128/32; gain_r=512, gain_g=256, gain_b=1024; gain_valid exactly 34 cycles after the last B sample.
- R=255, G=1, B=0 -> gain_r=1 (256/255 floored), gain_b=4095 (divide-by-zero); latency still 34 cycles.
- R=4, G=255, B=255 -> q=16320 clamps to gain_r=4095; gain_b=256.
- Samples driven during DIV_R -> in_ready=0, samples dropped, drop_err=1. Next clean frame (R=G=B=100) gives gains 256/256/256; drop_err stays 1.
- rst pulsed mid-DIV_B -> next cycle shows gains 256, means 0, busy 0, no gain_valid. Following frame completes normally.
- Frame interleaved with VOID samples and valid_in gaps of 0-3 cycles -> results identical to the gap-free frame of the first case.
